// File: rtl/nand_flash_pkg.sv
// Shared definitions for the paged NAND flash model.
//   OP_*     : cmd_op encodings (READ, PROG, BLK_ERASE, CHIP_ERASE)
//   state_t  : control FSM state encoding, also exported on the debug port
package nand_flash_pkg;

  localparam logic [1:0] OP_READ       = 2'b00;
  localparam logic [1:0] OP_PROG       = 2'b01;
  localparam logic [1:0] OP_BLK_ERASE  = 2'b10;
  localparam logic [1:0] OP_CHIP_ERASE = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_PROG  = 3'd2,
    ST_ERASE = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

endpackage

// File: rtl/nand_flash_array.sv
// Storage array for the NAND flash model: DATA_W x 2**ADDR_W words, every
// word starting out erased (all ones). Single shared address; the write is
// synchronous, the read is combinational so the controller can check and
// capture the addressed word in the same cycle.
//   clk   : write clock
//   addr  : word address shared by read and write
//   we    : write enable
//   wdata : write data
//   rdata : contents of mem[addr]
// The array has no reset: contents survive controller resets.
module nand_flash_array
  import nand_flash_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  // Power-up contents are the erased state.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '1};

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/nand_flash_paged.sv
// Block-structured NAND flash model with program busy time, block/chip erase,
// write protect and error reporting.
// Handshake: a command is accepted on a rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high only in IDLE, and cmd_valid
// presented while busy is ignored (the master holds it until cmd_ready).
//   clk, rst_n  : clock, synchronous active-low reset
//   cmd_*       : command request (op, word address, program data)
//   wp_n        : write protect, active low, sampled at accept
//   rdata/rvalid: read data with one-cycle valid pulse
//   done/err    : one-cycle completion pulse for PROG/erase, err on failure
//   busy        : high whenever not IDLE
//   dbg_state   : current FSM state
module nand_flash_paged
  import nand_flash_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int BLK_OFF_W   = 2,
  parameter int PROG_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic              wp_n,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              done,
  output logic              err,
  output logic              busy,
  output state_t            dbg_state
);

  localparam int CNT_W = (PROG_CYCLES > 1) ? $clog2(PROG_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] BLK_MASK = ADDR_W'((1 << BLK_OFF_W) - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;   // program address, or erase pointer
  logic [ADDR_W-1:0] end_q, end_d;     // last word of the erase range
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  nand_flash_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .addr  (mem_addr),
    .we    (mem_we),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      end_q   <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      end_q   <= end_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    end_d     = end_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    mem_addr  = addr_q;
    mem_we    = 1'b0;
    mem_wdata = wdata_q;

    case (state_q)
      ST_IDLE: begin
        // The array is addressed straight from the command so a READ can
        // capture its data on the accept edge.
        mem_addr = cmd_addr;
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          err_d   = 1'b0;
          if (cmd_op == OP_READ) begin
            rdata_d = mem_rdata;
            state_d = ST_READ;
          end else if (!wp_n) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else if (cmd_op == OP_PROG) begin
            cnt_d   = CNT_W'(PROG_CYCLES - 1);
            state_d = ST_PROG;
          end else if (cmd_op == OP_BLK_ERASE) begin
            addr_d  = cmd_addr & ~BLK_MASK;
            end_d   = cmd_addr | BLK_MASK;
            state_d = ST_ERASE;
          end else begin
            addr_d  = '0;
            end_d   = '1;
            state_d = ST_ERASE;
          end
        end
      end
      ST_READ: state_d = ST_IDLE;
      ST_PROG: begin
        if (cnt_q == '0) begin
          // Program may only clear bits; any 0->1 request fails untouched.
          // Gating with rst_n keeps a reset on the commit edge from writing.
          if ((mem_rdata & wdata_q) == wdata_q) mem_we = rst_n;
          else                                  err_d  = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_ERASE: begin
        mem_we    = rst_n;
        mem_wdata = '1;
        if (addr_q == end_q) state_d = ST_RESP;
        else                 addr_d  = addr_q + 1'b1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rvalid    = (state_q == ST_READ);
  assign done      = (state_q == ST_RESP);
  assign err       = (state_q == ST_RESP) && err_q;
  assign rdata     = rdata_q;
  assign dbg_state = state_q;

endmodule
